// File: rtl/fifo_stream_unpack.sv
// fifo_stream_unpack: rebuilds 32-bit packed ADC words (3x10-bit samples + 2-bit trigger tag) from a byte stream.
// Optional FIFO_UNPACK_SKID_EN adds a holding word so byte collection overlaps sample emission.
module fifo_stream_unpack #(
    parameter int CNT_W = 32
) (
    input  logic             clk_usb,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic [9:0]       sample_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             sample_trig_o,
    output logic [CNT_W-1:0] sample_count_o,
    output logic             trig_seen_o,
    output logic [CNT_W-1:0] trig_index_o,
    output logic             tag_err_o
);
    typedef enum logic [1:0] {COLLECT, EMIT0, EMIT1, EMIT2} state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [23:0]      part_q, part_d;
    logic [19:0]      upper_q, upper_d;
    logic [9:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             strig_q, strig_d;
    logic             word_trig_q, word_trig_d;
    logic [1:0]       word_tag_q, word_tag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             seen_q, seen_d;
    logic [1:0]       lat_tag_q, lat_tag_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             err_q, err_d;

    logic        restart;
    logic        byte_take;
    logic        sample_take;
    logic        word_done;
    logic        load;
    logic [31:0] full_word;
    logic [31:0] load_word;
    logic [1:0]  load_tag;

    assign restart     = reset_i | clear_i;
    assign full_word   = {part_q, byte_i};
    assign sample_take = valid_q & sample_ready_i;
    assign byte_take   = byte_valid_i & byte_ready_o;
    assign word_done   = byte_take & (phase_q == 2'd3);
    assign load_tag    = load_word[31:30];

`ifdef FIFO_UNPACK_SKID_EN
    logic [31:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        emit_free;

    // The emitter can take a new word when idle or when its last slot leaves this cycle.
    assign emit_free    = (state_q == COLLECT) | ((state_q == EMIT2) & sample_take);
    assign byte_ready_o = ~restart & ~hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        load_word   = full_word;
        if (hold_full_q) begin
            if (emit_free) begin
                load        = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end
        end else if (word_done) begin
            if (emit_free) begin
                load = 1'b1;
            end else begin
                hold_d      = full_word;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_usb) begin
        if (restart) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`else
    assign byte_ready_o = ~restart & (state_q == COLLECT);
    assign load         = word_done;
    assign load_word    = full_word;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        part_d      = part_q;
        upper_d     = upper_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        strig_d     = strig_q;
        word_trig_d = word_trig_q;
        word_tag_d  = word_tag_q;
        seen_d      = seen_q;
        lat_tag_d   = lat_tag_q;
        index_d     = index_q;
        err_d       = err_q;
        count_d     = count_q + CNT_W'(sample_take);

        if (byte_take) begin
            phase_d = phase_q + 2'd1;
            part_d  = {part_q[15:0], byte_i};
        end

        if (sample_take) begin
            case (state_q)
                EMIT0: begin
                    state_d  = EMIT1;
                    sample_d = upper_q[9:0];
                    strig_d  = word_trig_q & (word_tag_q == 2'd1);
                end
                EMIT1: begin
                    state_d  = EMIT2;
                    sample_d = upper_q[19:10];
                    strig_d  = word_trig_q & (word_tag_q == 2'd2);
                end
                EMIT2: begin
                    state_d = COLLECT;
                    valid_d = 1'b0;
                    strig_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Status flags update together with s0; count_d already includes any transfer this cycle.
        if (load) begin
            state_d    = EMIT0;
            upper_d    = load_word[29:10];
            sample_d   = load_word[9:0];
            valid_d    = 1'b1;
            word_tag_d = load_tag;
            if (!seen_q && (load_tag != 2'd3)) begin
                seen_d      = 1'b1;
                lat_tag_d   = load_tag;
                index_d     = count_d + CNT_W'(load_tag);
                word_trig_d = 1'b1;
                strig_d     = (load_tag == 2'd0);
            end else begin
                word_trig_d = 1'b0;
                strig_d     = 1'b0;
                if (seen_q && (load_tag != lat_tag_q)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_usb) begin
        if (restart) begin
            state_q     <= COLLECT;
            phase_q     <= '0;
            part_q      <= '0;
            upper_q     <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            strig_q     <= 1'b0;
            word_trig_q <= 1'b0;
            word_tag_q  <= '0;
            count_q     <= '0;
            seen_q      <= 1'b0;
            lat_tag_q   <= '0;
            index_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            part_q      <= part_d;
            upper_q     <= upper_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            strig_q     <= strig_d;
            word_trig_q <= word_trig_d;
            word_tag_q  <= word_tag_d;
            count_q     <= count_d;
            seen_q      <= seen_d;
            lat_tag_q   <= lat_tag_d;
            index_q     <= index_d;
            err_q       <= err_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign sample_trig_o  = strig_q;
    assign sample_count_o = count_q;
    assign trig_seen_o    = seen_q;
    assign trig_index_o   = index_q;
    assign tag_err_o      = err_q;
endmodule

// File: tb/tb_fifo_stream_unpack.sv
// tb_fifo_stream_unpack: scoreboard bench for fifo_stream_unpack; expected samples are queued as words are driven.
// Covers both builds; FIFO_UNPACK_SKID_EN selects the skid-specific expectations.
module tb_fifo_stream_unpack;
    localparam int CNT_W = 32;

    logic             clk_usb = 1'b0;
    logic             reset_i;
    logic             clear_i;
    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             byte_ready_o;
    logic [9:0]       sample_o;
    logic             sample_valid_o;
    logic             sample_ready_i;
    logic             sample_trig_o;
    logic [CNT_W-1:0] sample_count_o;
    logic             trig_seen_o;
    logic [CNT_W-1:0] trig_index_o;
    logic             tag_err_o;

    int checks = 0;
    int failures = 0;
    int rx_count = 0;
    int cyc = 0;

    logic [10:0] exp_q[$];
    logic [10:0] mon_exp;

    // Reference model state for trigger tracking, reset on every clear.
    int          m_pushed = 0;
    bit          m_seen = 0;
    logic [1:0]  m_tag = '0;
    int          m_index = 0;
    bit          m_err = 0;

    fifo_stream_unpack #(.CNT_W(CNT_W)) dut (
        .clk_usb        (clk_usb),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_ready_o   (byte_ready_o),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_trig_o  (sample_trig_o),
        .sample_count_o (sample_count_o),
        .trig_seen_o    (trig_seen_o),
        .trig_index_o   (trig_index_o),
        .tag_err_o      (tag_err_o)
    );

    always #5 clk_usb = ~clk_usb;

    always @(posedge clk_usb) cyc++;

    // Every sample transfer is matched against the head of the scoreboard.
    always @(negedge clk_usb) begin
        if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_sample got=%h expected=none", sample_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sample_trig_o, sample_o} !== mon_exp) begin
                    failures++;
                    $display("[TB] FAIL sample_%0d got trig=%b data=%h expected trig=%b data=%h",
                             rx_count, sample_trig_o, sample_o, mon_exp[10], mon_exp[9:0]);
                end
            end
            rx_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout got=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic model_reset();
        m_pushed = 0;
        m_seen   = 0;
        m_tag    = '0;
        m_index  = 0;
        m_err    = 0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        logic [1:0] t;
        bit         is_trig;
        t = w[31:30];
        is_trig = !m_seen && (t != 2'd3);
        if (is_trig) begin
            m_seen  = 1;
            m_tag   = t;
            m_index = m_pushed + int'(t);
        end else if (m_seen && t != m_tag) begin
            m_err = 1;
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({is_trig && (i == int'(t)), w[10*i +: 10]});
        end
        m_pushed += 3;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        forever begin
            @(negedge clk_usb);
            if (byte_ready_o === 1'b1) begin
                step();
                byte_valid_i = 1'b0;
                break;
            end
            step();
            n++;
            if (n > 500) begin
                checks++;
                failures++;
                $display("[TB] FAIL byte_accept_timeout got=not_ready expected=ready");
                byte_valid_i = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        push_word(w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_drain got=%0d_pending expected=0_pending", name, exp_q.size());
        end
        step();
        step();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        clear_i = 1'b0;
        byte_valid_i = 1'b1;
        byte_i = 8'hA5;
        sample_ready_i = 1'b1;
        step();
        step();
        @(negedge clk_usb);
        checks += 7;
        if (byte_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_byte_ready got=%b expected=0", byte_ready_o); end
        if (sample_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b expected=0", sample_valid_o); end
        if (sample_trig_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_trig got=%b expected=0", sample_trig_o); end
        if (sample_o !== 10'd0) begin failures++; $display("[TB] FAIL reset_sample got=%h expected=0", sample_o); end
        if (sample_count_o !== '0) begin failures++; $display("[TB] FAIL reset_count got=%0d expected=0", sample_count_o); end
        if (trig_seen_o !== 1'b0 || trig_index_o !== '0) begin failures++; $display("[TB] FAIL reset_trig_status got=%b/%0d expected=0/0", trig_seen_o, trig_index_o); end
        if (tag_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_tag_err got=%b expected=0", tag_err_o); end
        step();
        reset_i = 1'b0;
        byte_valid_i = 1'b0;
        model_reset();
        @(negedge clk_usb);
        checks++;
        if (byte_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_byte_ready got=%b expected=1", byte_ready_o); end
        step();
    endtask

    task automatic test_basic();
        do_clear();
        sample_ready_i = 1'b1;
        send_word(32'h3FF0_0801);
        @(negedge clk_usb);
        checks += 2;
        if (sample_valid_o !== 1'b1 || sample_o !== 10'h001) begin failures++; $display("[TB] FAIL basic_latency got=%b/%h expected=1/001", sample_valid_o, sample_o); end
        if (trig_seen_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_seen_timing got=%b expected=1", trig_seen_o); end
        step();
        wait_drain("basic");
        checks += 2;
        if (trig_index_o !== 32'd0) begin failures++; $display("[TB] FAIL basic_trig_index got=%0d expected=0", trig_index_o); end
        if (sample_count_o !== 32'd3) begin failures++; $display("[TB] FAIL basic_count got=%0d expected=3", sample_count_o); end
    endtask

    task automatic test_trigger_offset();
        do_clear();
        send_word(32'hC000_0000);
        send_word(32'h8010_0C03);
        wait_drain("trig_offset");
        checks += 4;
        if (trig_index_o !== 32'd5) begin failures++; $display("[TB] FAIL trig_offset_index got=%0d expected=5", trig_index_o); end
        if (trig_seen_o !== 1'b1) begin failures++; $display("[TB] FAIL trig_offset_seen got=%b expected=1", trig_seen_o); end
        if (tag_err_o !== 1'b0) begin failures++; $display("[TB] FAIL trig_offset_tag_err got=%b expected=0", tag_err_o); end
        if (sample_count_o !== 32'd6) begin failures++; $display("[TB] FAIL trig_offset_count got=%0d expected=6", sample_count_o); end
    endtask

    task automatic test_tag_error();
        do_clear();
        send_word(32'h4000_0000);
        @(negedge clk_usb);
        checks++;
        if (tag_err_o !== 1'b0) begin failures++; $display("[TB] FAIL tag_err_early got=%b expected=0", tag_err_o); end
        step();
        send_word(32'h8000_0000);
        @(negedge clk_usb);
        checks++;
        if (tag_err_o !== 1'b1) begin failures++; $display("[TB] FAIL tag_err_timing got=%b expected=1", tag_err_o); end
        step();
        wait_drain("tag_err");
        checks += 3;
        if (tag_err_o !== 1'(m_err)) begin failures++; $display("[TB] FAIL tag_err_sticky got=%b expected=%b", tag_err_o, m_err); end
        if (trig_index_o !== CNT_W'(m_index)) begin failures++; $display("[TB] FAIL tag_err_index got=%0d expected=%0d", trig_index_o, m_index); end
        if (sample_count_o !== 32'd6) begin failures++; $display("[TB] FAIL tag_err_count got=%0d expected=6", sample_count_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w1;
        logic [31:0] w2;
        int          unstable;
        int          ready_high;
        w1 = 32'hC5A6_93B7;
        w2 = 32'h4ABC_DE12;
        unstable = 0;
        ready_high = 0;
        do_clear();
        sample_ready_i = 1'b0;
        send_word(w1);
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
`ifdef FIFO_UNPACK_SKID_EN
        send_word(w2);
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_usb);
            if (sample_valid_o !== 1'b1 || sample_o !== w1[19:10]) unstable++;
            if (byte_ready_o !== 1'b0) ready_high++;
            step();
        end
        checks += 2;
        if (unstable !== 0) begin failures++; $display("[TB] FAIL stall_stable got=%0d_changes expected=0", unstable); end
        if (ready_high !== 0) begin failures++; $display("[TB] FAIL stall_byte_ready got=%0d_high expected=0", ready_high); end
        sample_ready_i = 1'b1;
`ifndef FIFO_UNPACK_SKID_EN
        send_word(w2);
`endif
        wait_drain("backpressure");
        checks += 2;
        if (sample_count_o !== 32'd6) begin failures++; $display("[TB] FAIL backpressure_count got=%0d expected=6", sample_count_o); end
        if (trig_seen_o !== 1'b1 || trig_index_o !== CNT_W'(m_index)) begin failures++; $display("[TB] FAIL backpressure_trig got=%b/%0d expected=1/%0d", trig_seen_o, trig_index_o, m_index); end
    endtask

    task automatic test_clear_mid_word();
        send_byte(8'h11);
        send_byte(8'h22);
        clear_i = 1'b1;
        byte_i = 8'h33;
        byte_valid_i = 1'b1;
        @(negedge clk_usb);
        checks++;
        if (byte_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL clear_byte_ready got=%b expected=0", byte_ready_o); end
        step();
        clear_i = 1'b0;
        byte_valid_i = 1'b0;
        model_reset();
        @(negedge clk_usb);
        checks += 2;
        if (sample_count_o !== 32'd0) begin failures++; $display("[TB] FAIL clear_count got=%0d expected=0", sample_count_o); end
        if (trig_seen_o !== 1'b0 || trig_index_o !== '0) begin failures++; $display("[TB] FAIL clear_trig got=%b/%0d expected=0/0", trig_seen_o, trig_index_o); end
        step();
        send_word(32'hC030_0802);
        wait_drain("clear");
        checks++;
        if (sample_count_o !== 32'd3) begin failures++; $display("[TB] FAIL clear_fresh_count got=%0d expected=3", sample_count_o); end
    endtask

    task automatic test_back_to_back();
        int start;
        int elapsed;
        int rx0;
        int n;
        do_clear();
        sample_ready_i = 1'b1;
        rx0 = rx_count;
        start = cyc;
        for (int k = 0; k < 100; k++) send_word($urandom);
        n = 0;
        while (rx_count - rx0 < 300 && n < 3000) begin
            @(negedge clk_usb);
            n++;
        end
        elapsed = cyc - start;
        step();
        step();
        checks += 3;
        if (rx_count - rx0 !== 300) begin failures++; $display("[TB] FAIL b2b_received got=%0d expected=300", rx_count - rx0); end
        if (sample_count_o !== 32'd300) begin failures++; $display("[TB] FAIL b2b_count got=%0d expected=300", sample_count_o); end
        if (trig_seen_o !== 1'(m_seen) || tag_err_o !== 1'(m_err) || (m_seen && trig_index_o !== CNT_W'(m_index))) begin
            failures++;
            $display("[TB] FAIL b2b_status got=%b/%b/%0d expected=%b/%b/%0d", trig_seen_o, tag_err_o, trig_index_o, m_seen, m_err, m_index);
        end
        checks++;
`ifdef FIFO_UNPACK_SKID_EN
        if (elapsed > 405) begin failures++; $display("[TB] FAIL b2b_cycles got=%0d expected<=405", elapsed); end
`else
        if (elapsed < 690) begin failures++; $display("[TB] FAIL b2b_cycles got=%0d expected>=690", elapsed); end
`endif
    endtask

    initial begin
        reset_i = 1'b1;
        clear_i = 1'b0;
        byte_i = '0;
        byte_valid_i = 1'b0;
        sample_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_trigger_offset();
        test_tag_error();
        test_backpressure();
        test_clear_mid_word();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
